shadow_wr_sequencer: RTL and testbench

Arbiter and sequencer that lets NumReq hardware requesters share a bank of NumRegs shadowed registers.
- Each requester issues one logical write.
- The block runs the mandatory two-write shadow update to the selected register: optional phase clear, first write, confirming write, then error check.
- It returns a per-transaction status.
- It sits between HW config masters (e.g. key/alert managers) and the shadowed-register bank's HW-side write ports.

---
 rtl/shadow_seq_pkg.sv | 26 ++
 rtl/shadow_seq_rr_arb.sv | 49 ++++
 rtl/shadow_wr_sequencer.sv | 169 ++++++++++++++++
 tb/tb_shadow_wr_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shadow_seq_pkg.sv
// ============================================================================
// shadow_seq_pkg: shared state and status encodings for the shadow sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package shadow_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        WR0   = 3'd2,
        WR1   = 3'd3,
        RESP  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OK          = 2'd0,
        ERR_UPDATE  = 2'd1,
        ERR_STORAGE = 2'd2,
        ERR_DECODE  = 2'd3
    } err_e;

endpackage

`default_nettype wire

// File: rtl/shadow_seq_rr_arb.sv
// ============================================================================
// shadow_seq_rr_arb: round-robin arbiter, pointer moves past each grant
// Revision: 1.0
// ============================================================================
`default_nettype none

module shadow_seq_rr_arb #(
    parameter int unsigned NumReq = 2,
    localparam int unsigned IDX_W = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    input  logic              advance_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IDX_W-1:0]  gnt_idx_o
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;

    // Scan offsets from the pointer; the first requesting slot wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            for (int j = 0; j < NumReq; j++) begin
                if (!w_found && req_i[j] &&
                    (((32'(r_ptr) + 32'(i)) % NumReq) == 32'(j))) begin
                    w_found   = 1'b1;
                    gnt_o[j]  = 1'b1;
                    gnt_idx_o = IDX_W'(j);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (advance_i && w_found) begin
            r_ptr <= (gnt_idx_o == IDX_W'(NumReq - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/shadow_wr_sequencer.sv
// ============================================================================
// shadow_wr_sequencer: arbitrates HW writers onto a shadowed register bank
// Revision: 1.0
// ============================================================================
`default_nettype none

module shadow_wr_sequencer
    import shadow_seq_pkg::*;
#(
    parameter int unsigned NumReq  = 2,
    parameter int unsigned NumRegs = 8,
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumReq-1:0]    req_valid_i,
    output logic [NumReq-1:0]    req_ready_o,
    input  logic [NumReq*AW-1:0] req_addr_i,
    input  logic [NumReq*DW-1:0] req_data_i,
    output logic [NumReq-1:0]    rsp_valid_o,
    output logic [1:0]           rsp_err_o,
    input  logic [NumReq-1:0]    rsp_ready_i,
    output logic [NumRegs-1:0]   reg_we_o,
    output logic [NumRegs-1:0]   reg_re_o,
    output logic [DW-1:0]        reg_wd_o,
    input  logic [NumRegs-1:0]   reg_phase_i,
    input  logic [NumRegs-1:0]   reg_err_update_i,
    input  logic [NumRegs-1:0]   reg_err_storage_i,
    output logic                 busy_o
);

    localparam int unsigned IDX_W = (NumReq > 1) ? $clog2(NumReq) : 1;

    state_e              r_state;
    logic [NumRegs-1:0]  r_sel;
    logic [DW-1:0]       r_data;
    logic [NumReq-1:0]   r_owner;
    logic [NumRegs-1:0]  r_we;
    logic [NumRegs-1:0]  r_re;
    logic [DW-1:0]       r_wd;
    logic [NumReq-1:0]   r_rsp_valid;
    err_e                r_rsp_err;
    logic                r_busy;

    logic [NumReq-1:0]   w_grant;
    logic [IDX_W-1:0]    w_gidx;
    logic                w_advance;
    logic [AW-1:0]       w_addr;
    logic [DW-1:0]       w_data;
    logic [NumRegs-1:0]  w_gsel;
    err_e                w_wr1_err;

    assign w_advance = (r_state == IDLE) && (|req_valid_i);

    shadow_seq_rr_arb #(
        .NumReq (NumReq)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_valid_i),
        .advance_i (w_advance),
        .gnt_o     (w_grant),
        .gnt_idx_o (w_gidx)
    );

    assign w_addr = req_addr_i[w_gidx*AW +: AW];
    assign w_data = req_data_i[w_gidx*DW +: DW];

    // An out-of-range address decodes to an all-zero select, which flags the decode error.
    always_comb begin
        w_gsel = '0;
        for (int i = 0; i < NumRegs; i++) begin
            w_gsel[i] = (w_addr == AW'(i));
        end
    end

    always_comb begin
        w_wr1_err = OK;
        if (|(reg_err_update_i & r_sel)) begin
            w_wr1_err = ERR_UPDATE;
        end else if (~|(reg_phase_i & r_sel)) begin
            w_wr1_err = ERR_UPDATE;
        end else if (|(reg_err_storage_i & r_sel)) begin
            w_wr1_err = ERR_STORAGE;
        end
    end

    // Strobes are registered on state entry, so each state's outputs line up with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_data      <= '0;
            r_owner     <= '0;
            r_we        <= '0;
            r_re        <= '0;
            r_wd        <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= OK;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_valid_i) begin
                        r_sel   <= w_gsel;
                        r_data  <= w_data;
                        r_owner <= w_grant;
                        r_busy  <= 1'b1;
                        if (w_gsel == '0) begin
                            r_state     <= RESP;
                            r_rsp_valid <= w_grant;
                            r_rsp_err   <= ERR_DECODE;
                        end else if (|(reg_err_storage_i & w_gsel)) begin
                            r_state     <= RESP;
                            r_rsp_valid <= w_grant;
                            r_rsp_err   <= ERR_STORAGE;
                        end else if (|(reg_phase_i & w_gsel)) begin
                            r_state <= CLEAR;
                            r_re    <= w_gsel;
                        end else begin
                            r_state <= WR0;
                            r_we    <= w_gsel;
                            r_wd    <= w_data;
                        end
                    end
                end
                CLEAR: begin
                    r_state <= WR0;
                    r_re    <= '0;
                    r_we    <= r_sel;
                    r_wd    <= r_data;
                end
                WR0: begin
                    r_state <= WR1;
                end
                WR1: begin
                    r_state     <= RESP;
                    r_we        <= '0;
                    r_wd        <= '0;
                    r_rsp_valid <= r_owner;
                    r_rsp_err   <= w_wr1_err;
                end
                RESP: begin
                    if (|(rsp_ready_i & r_owner)) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= '0;
                        r_rsp_err   <= OK;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (r_state == IDLE) ? w_grant : '0;
    assign reg_we_o    = r_we;
    assign reg_re_o    = r_re;
    assign reg_wd_o    = r_wd;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign busy_o      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_shadow_wr_sequencer.sv
// ============================================================================
// tb_shadow_wr_sequencer: directed self-checking bench with a toggling-phase bank
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shadow_wr_sequencer;

    localparam int NR  = 2;
    localparam int NG  = 8;
    localparam int DWL = 32;
    localparam int AWL = 4;

    logic              clk_i;
    logic              rst_ni;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR*AWL-1:0] req_addr_i;
    logic [NR*DWL-1:0] req_data_i;
    logic [NR-1:0]     rsp_valid_o;
    logic [1:0]        rsp_err_o;
    logic [NR-1:0]     rsp_ready_i;
    logic [NG-1:0]     reg_we_o;
    logic [NG-1:0]     reg_re_o;
    logic [DWL-1:0]    reg_wd_o;
    logic [NG-1:0]     reg_phase_i;
    logic [NG-1:0]     reg_err_update_i;
    logic [NG-1:0]     reg_err_storage_i;
    logic              busy_o;

    logic [NG-1:0]     bank_phase;
    logic [NG-1:0]     phase_inj;
    int                we_cnt;
    logic              overlap_seen;
    int                checks;
    int                failures;
    int                snap;

    shadow_wr_sequencer #(
        .NumReq  (NR),
        .NumRegs (NG),
        .DW      (DWL),
        .AW      (AWL)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_addr_i        (req_addr_i),
        .req_data_i        (req_data_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_err_o         (rsp_err_o),
        .rsp_ready_i       (rsp_ready_i),
        .reg_we_o          (reg_we_o),
        .reg_re_o          (reg_re_o),
        .reg_wd_o          (reg_wd_o),
        .reg_phase_i       (reg_phase_i),
        .reg_err_update_i  (reg_err_update_i),
        .reg_err_storage_i (reg_err_storage_i),
        .busy_o            (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Bank model: a write toggles the phase, a read clears it.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_phase <= '0;
        end else begin
            bank_phase <= (bank_phase ^ reg_we_o) & ~reg_re_o;
        end
    end
    assign reg_phase_i = bank_phase | phase_inj;

    initial begin
        we_cnt       = 0;
        overlap_seen = 1'b0;
    end
    always @(posedge clk_i) begin
        if (|reg_we_o) we_cnt <= we_cnt + 1;
        if ((|reg_we_o && |reg_re_o) || $countones(reg_we_o) > 1 || $countones(reg_re_o) > 1)
            overlap_seen <= 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input int r, input logic [AWL-1:0] a, input logic [DWL-1:0] d,
                         input logic [NR-1:0] exp_rdy);
        req_addr_i[r*AWL +: AWL] = a;
        req_data_i[r*DWL +: DWL] = d;
        req_valid_i[r]           = 1'b1;
        #1;
        check("grant_ready", req_ready_o, exp_rdy);
        step();
        req_valid_i[r] = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (rsp_valid_o == '0 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("rsp_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (req_ready_o == '0 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("ready_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst_ni            = 1'b0;
        req_valid_i       = '0;
        req_addr_i        = '0;
        req_data_i        = '0;
        rsp_ready_i       = 2'b11;
        phase_inj         = '0;
        reg_err_update_i  = '0;
        reg_err_storage_i = '0;

        // Reset state
        step();
        step();
        check("rst_busy", busy_o, 1'b0);
        check("rst_we", reg_we_o, 8'h00);
        check("rst_rsp_valid", rsp_valid_o, 2'b00);
        check("rst_wd", reg_wd_o, 32'h0);
        rst_ni = 1'b1;
        step();

        // Single write, no clear needed
        issue(0, 4'd3, 32'hA5A5_0001, 2'b01);
        check("single_we_t1", reg_we_o, 8'h08);
        check("single_wd_t1", reg_wd_o, 32'hA5A5_0001);
        check("single_busy", busy_o, 1'b1);
        step();
        check("single_we_t2", reg_we_o, 8'h08);
        check("single_wd_t2", reg_wd_o, 32'hA5A5_0001);
        step();
        check("single_we_t3", reg_we_o, 8'h00);
        check("single_wd_t3", reg_wd_o, 32'h0);
        check("single_rsp_valid", rsp_valid_o, 2'b01);
        check("single_rsp_err", rsp_err_o, 2'd0);
        step();
        check("single_idle_busy", busy_o, 1'b0);
        check("single_idle_rsp", rsp_valid_o, 2'b00);

        // Stale phase forces a clear first; pointer now at requester 1
        phase_inj = 8'h20;
        issue(1, 4'd5, 32'h1234_5678, 2'b10);
        check("stale_re_t1", reg_re_o, 8'h20);
        check("stale_we_t1", reg_we_o, 8'h00);
        step();
        check("stale_we_t2", reg_we_o, 8'h20);
        check("stale_re_t2", reg_re_o, 8'h00);
        step();
        check("stale_we_t3", reg_we_o, 8'h20);
        step();
        check("stale_rsp_valid", rsp_valid_o, 2'b10);
        check("stale_rsp_err", rsp_err_o, 2'd0);
        phase_inj = '0;
        step();

        // Contention: both valid, grants alternate starting at 0
        req_addr_i  = {4'd2, 4'd1};
        req_data_i  = {32'hBBBB_0002, 32'hAAAA_0001};
        req_valid_i = 2'b11;
        #1;
        for (int g = 0; g < 4; g++) begin
            wait_ready();
            check("cont_grant", req_ready_o, (g % 2 == 0) ? 2'b01 : 2'b10);
            step();
            if (g == 3) req_valid_i = 2'b00;
            wait_rsp();
            check("cont_owner", rsp_valid_o, (g % 2 == 0) ? 2'b01 : 2'b10);
            check("cont_err", rsp_err_o, 2'd0);
        end
        step();

        // Update error during the confirming write
        reg_err_update_i = 8'h04;
        snap = we_cnt;
        issue(0, 4'd2, 32'hCAFE_0002, 2'b01);
        wait_rsp();
        check("upd_owner", rsp_valid_o, 2'b01);
        check("upd_err", rsp_err_o, 2'd1);
        step();
        check("upd_we_pulses", 32'(we_cnt - snap), 32'd2);
        reg_err_update_i = '0;

        // Decode reject
        snap = we_cnt;
        issue(1, 4'd9, 32'hDEAD_0009, 2'b10);
        check("dec_rsp_valid", rsp_valid_o, 2'b10);
        check("dec_rsp_err", rsp_err_o, 2'd3);
        check("dec_we", reg_we_o, 8'h00);
        check("dec_re", reg_re_o, 8'h00);
        step();
        check("dec_idle", busy_o, 1'b0);

        // Storage reject
        reg_err_storage_i = 8'h02;
        issue(0, 4'd1, 32'hBEEF_0001, 2'b01);
        check("sto_rsp_valid", rsp_valid_o, 2'b01);
        check("sto_rsp_err", rsp_err_o, 2'd2);
        check("sto_we", reg_we_o, 8'h00);
        step();
        check("sto_no_writes", 32'(we_cnt - snap), 32'd0);
        reg_err_storage_i = '0;

        // Response backpressure
        rsp_ready_i = 2'b00;
        issue(1, 4'd4, 32'h0404_0404, 2'b10);
        wait_rsp();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", rsp_valid_o, 2'b10);
            check("bp_err", rsp_err_o, 2'd0);
            check("bp_busy", busy_o, 1'b1);
            step();
        end
        rsp_ready_i = 2'b11;
        step();
        check("bp_release_busy", busy_o, 1'b0);
        check("bp_release_valid", rsp_valid_o, 2'b00);

        // Reset in WR0 abandons the transaction and rewinds the pointer
        issue(0, 4'd6, 32'h0606_0606, 2'b01);
        check("rst_mid_we", reg_we_o, 8'h40);
        rst_ni = 1'b0;
        #1;
        check("rst_mid_we0", reg_we_o, 8'h00);
        check("rst_mid_wd0", reg_wd_o, 32'h0);
        check("rst_mid_busy0", busy_o, 1'b0);
        check("rst_mid_rsp0", rsp_valid_o, 2'b00);
        check("rst_mid_ready0", req_ready_o, 2'b00);
        step();
        rst_ni      = 1'b1;
        req_addr_i  = {4'd7, 4'd0};
        req_valid_i = 2'b11;
        #1;
        check("post_rst_grant", req_ready_o, 2'b01);
        step();
        req_valid_i = 2'b00;
        wait_rsp();
        check("post_rst_owner", rsp_valid_o, 2'b01);
        check("post_rst_err", rsp_err_o, 2'd0);
        step();

        check("strobe_overlap", overlap_seen, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
